// File: rtl/dct2_row_sequencer.sv
// Block controller for the combinational 1-D DCT-II core: streams N rows of one
// block through a two-stage register pipeline around the core and tags each output row.
module dct2_row_sequencer #(
    parameter int DATA_W = 16,
    parameter int LANES  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               size,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_data,
    output logic [LANES*DATA_W-1:0]  core_x,
    output logic [1:0]               core_n,
    input  logic [LANES*DATA_W-1:0]  core_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*DATA_W-1:0]  out_data,
    output logic [4:0]               out_row,
    output logic                     out_last,
    output logic [1:0]               fsm_state
);

    // Both streams use valid/ready: a transfer happens on a rising edge where
    // valid && ready; the source holds its payload stable until then.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [5:0]                rows_in;
    logic [5:0]                rows_out;
    logic [5:0]                rows_total;
    logic                      s1_v;
    logic                      s2_v;
    logic                      s1_adv;
    logic                      in_accept;
    logic                      out_fire;
    logic                      start_accept;
    logic [LANES*DATA_W-1:0]   lane_mask;

    assign rows_total = 6'd4 << core_n;
    assign s1_adv     = s1_v && (!s2_v || out_ready);
    assign out_fire   = s2_v && out_ready;
    assign in_accept  = in_valid && in_ready;
    assign out_valid  = s2_v;
    assign busy       = (state != IDLE);
    assign fsm_state  = state;

    // Lanes beyond the block size carry no samples and must reach neither core nor output.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(rows_total))
                lane_mask[i*DATA_W +: DATA_W] = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                in_ready = (rows_in < rows_total) && (!s1_v || s1_adv);
                if (in_valid && in_ready && (rows_in == rows_total - 6'd1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_fire && out_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_n   <= 2'b00;
            rows_in  <= '0;
            rows_out <= '0;
            core_x   <= '0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            out_data <= '0;
            out_row  <= '0;
            out_last <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == DRAIN) && out_fire && out_last;
            if (start_accept) begin
                core_n   <= size;
                rows_in  <= '0;
                rows_out <= '0;
            end
            if (in_accept) begin
                core_x  <= in_data & lane_mask;
                rows_in <= rows_in + 6'd1;
                s1_v    <= 1'b1;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end
            // A drain and a load in the same cycle keep s2 full for back-to-back rows.
            if (s1_adv) begin
                out_data <= core_y & lane_mask;
                out_row  <= rows_out[4:0];
                out_last <= (rows_out == rows_total - 6'd1);
                rows_out <= rows_out + 6'd1;
                s2_v     <= 1'b1;
            end else if (out_fire) begin
                s2_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dct2_row_sequencer.sv
// Bench for dct2_row_sequencer: a stand-in lane-mixing core, a cycle model of
// the handshakes and a scoreboard of expected output rows.
module tb_dct2_row_sequencer;

    localparam int DATA_W = 16;
    localparam int LANES  = 32;
    localparam int W      = LANES * DATA_W;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [1:0]     size;
    logic           busy;
    logic           done;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [W-1:0]   core_x;
    logic [1:0]     core_n;
    logic [W-1:0]   core_y;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [4:0]     out_row;
    logic           out_last;
    logic [1:0]     fsm_state;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [4:0]   exp_row_q[$];
    logic         exp_last_q[$];

    // Cycle model of the block as seen from its ports.
    bit       active;
    bit       was_active;
    bit       m_s1;
    bit       m_s2;
    bit       m_adv;
    bit       m_rdy;
    bit       done_exp;
    bit       front_last;
    logic [1:0] m_n;
    int       rows_in_m;
    int       m_r;
    int       out_total;
    int       out_base;
    int       ready_mode;
    int       stall_cnt;

    dct2_row_sequencer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .size      (size),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .core_x    (core_x),
        .core_n    (core_n),
        .core_y    (core_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in core: lane mixing so that an unzeroed input lane leaks into lane R-1.
    function automatic logic [W-1:0] core_fn(input logic [W-1:0] x, input logic [1:0] n);
        logic [W-1:0]        y;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        y = '0;
        for (int i = 0; i < LANES; i++) begin
            a = x[i*DATA_W +: DATA_W];
            b = x[((i + 1) % LANES)*DATA_W +: DATA_W];
            y[i*DATA_W +: DATA_W] = a * 16'd3 + b + 16'(i) + 16'(7 * int'(n)) + 16'd1;
        end
        return y;
    endfunction

    function automatic logic [W-1:0] model_row(input logic [W-1:0] x, input logic [1:0] n);
        logic [W-1:0] xm;
        logic [W-1:0] y;
        logic [W-1:0] r;
        int           nr;
        nr = 4 << n;
        xm = '0;
        r  = '0;
        for (int i = 0; i < nr; i++) xm[i*DATA_W +: DATA_W] = x[i*DATA_W +: DATA_W];
        y = core_fn(xm, n);
        for (int i = 0; i < nr; i++) r[i*DATA_W +: DATA_W] = y[i*DATA_W +: DATA_W];
        return r;
    endfunction

    always_comb core_y = core_fn(core_x, core_n);

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_row", out_row, 0);
        check("rst_core_x", core_x, 0);
        check("rst_out_data", out_data, 0);
        check("rst_core_n", core_n, 0);
        check("rst_state", fsm_state, 0);
    endtask

    // ---------------- scoreboard / model monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_row_q.delete();
            exp_last_q.delete();
            active    = 0;
            m_s1      = 0;
            m_s2      = 0;
            done_exp  = 0;
            rows_in_m = 0;
            m_n       = 2'b00;
        end else begin
            was_active = active;
            m_r   = 4 << m_n;
            m_adv = m_s1 && (!m_s2 || out_ready);
            m_rdy = active && (rows_in_m < m_r) && (!m_s1 || m_adv);
            check("in_ready", in_ready, m_rdy);
            check("out_valid", out_valid, m_s2);
            check("busy", busy, active);
            check("done", done, done_exp);
            if (active) check("core_n", core_n, m_n);
            done_exp = 0;
            if (m_s2) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    check("out_row", out_row, exp_row_q[0]);
                    check("out_last", out_last, exp_last_q[0]);
                    if (out_ready) begin
                        front_last = exp_last_q[0];
                        void'(exp_q.pop_front());
                        void'(exp_row_q.pop_front());
                        void'(exp_last_q.pop_front());
                        out_total++;
                        if (front_last) begin
                            done_exp = 1;
                            active   = 0;
                        end
                    end
                end
            end
            if (in_valid && m_rdy) begin
                exp_q.push_back(model_row(in_data, m_n));
                exp_row_q.push_back(5'(rows_in_m));
                exp_last_q.push_back(rows_in_m == m_r - 1);
                rows_in_m++;
            end
            if (m_adv) m_s2 = 1;
            else if (m_s2 && out_ready) m_s2 = 0;
            if (in_valid && m_rdy) m_s1 = 1;
            else if (m_adv) m_s1 = 0;
            if (start && !was_active) begin
                active    = 1;
                m_n       = size;
                rows_in_m = 0;
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        out_ready = 1'b1;
        stall_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = !out_ready;
                2: begin
                    if ((out_total - out_base) == 4 && stall_cnt < 5) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: begin
                    out_ready = 1'b1;
                    stall_cnt = 0;
                end
            endcase
        end
    end

    task automatic start_block(input logic [1:0] sz);
        @(posedge clk);
        #1;
        start = 1'b1;
        size  = sz;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // pat 0: every lane of row r holds r+1; otherwise random lanes.
    task automatic send_rows(input int nrows, input int gap_max, input int pat);
        bit hs;
        for (int r = 0; r < nrows; r++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            for (int l = 0; l < LANES; l++)
                in_data[l*DATA_W +: DATA_W] = (pat == 0) ? 16'(r + 1) : 16'($urandom);
            hs = 0;
            for (int c = 0; c < 500 && !hs; c++) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
            end
            if (!hs) check("in_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        size       = 2'b00;
        in_valid   = 1'b0;
        in_data    = '0;
        ready_mode = 0;
        out_base   = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        #2 rst_n = 1'b1;

        // Reset in the middle of a 32-row block.
        start_block(2'b11);
        send_rows(10, 0, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // R=4 with constant rows, then a second R=4 block back to back.
        start_block(2'b00);
        send_rows(4, 0, 0);
        wait_done();
        start_block(2'b00);
        send_rows(4, 0, 1);
        wait_done();

        // R=32 with out_ready toggling every cycle.
        ready_mode = 1;
        start_block(2'b11);
        send_rows(32, 0, 1);
        wait_done();
        ready_mode = 0;

        // Start during RUN with another size must be ignored.
        start_block(2'b01);
        fork
            send_rows(8, 0, 1);
            begin
                repeat (3) @(posedge clk);
                #1;
                start = 1'b1;
                size  = 2'b11;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        wait_done();

        // R=8 with input gaps and a 5-cycle stall in front of row 4.
        out_base   = out_total;
        ready_mode = 2;
        start_block(2'b01);
        send_rows(8, 3, 1);
        wait_done();
        check("r8_out_count", out_total - out_base, 8);
        ready_mode = 0;

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        check("end_state", fsm_state, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dct2_row_sequencer.md
Name: dct2_row_sequencer

Overview:
- Block-level controller for the combinational 1-D DCT-II core, which takes 32x16-bit lanes in, a 2-bit size select, and returns 32x16-bit lanes out.
- Accepts one configured block of N rows (N = 4/8/16/32) from an upstream valid/ready stream and feeds each row through the core.
- Holds the core size select stable for the whole block, registers the core results and returns them downstream with row index and last-row flags.
- Sits between the residual row source and the transpose/column stage.

Parameters:
- DATA_W, 16, bits per sample lane (core lane width; fixed at 16 in this release)
- LANES, 32, lanes per row vector (maximum transform size)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  block start request; sampled only in IDLE
- size  in  2  block size: 00=4, 01=8, 10=16, 11=32; latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last output row handshake
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid && in_ready
- in_data  in  LANES*DATA_W  input row, lane i = in_data[16i+15:16i]
- core_x  out  LANES*DATA_W  registered row driven to the core, same lane packing
- core_n  out  2  size select to the core; equals the latched size
- core_y  in  LANES*DATA_W  core result, lane i = core_y[16i+15:16i], combinational from core_x/core_n
- out_valid  out  1  output row valid
- out_ready  in  1  downstream ready
- out_data  out  LANES*DATA_W  registered transform row
- out_row  out  5  row index 0..N-1 of out_data
- out_last  out  1  high with the final row of the block

Behaviour:
- Reset (async, rst_n=0) clears all state and outputs:
  - state=IDLE; busy, done, in_ready, out_valid, out_last = 0
  - out_row=0; core_x, out_data = 0; core_n=00
  - Reset mid-block discards all rows; no done is produced.
- Rows per block R = 4 << size.
- State IDLE:
  - in_ready=0.
  - start=1 latches size into core_n, clears the counters rows_in and rows_out, and moves to RUN.
  - The row is never accepted in the same cycle as start.
- State RUN:
  - in_ready = (rows_in < R) && (!s1_v || s1_adv).
  - Accepted row: lanes >= R are forced to 0, the result is loaded into the stage-1 register (core_x), s1_v is set and rows_in is incremented.
  - When rows_in reaches R, move to DRAIN. The transition happens on the edge that accepts row R-1.
- State DRAIN:
  - in_ready=0.
  - Wait for the handshake of the last output row, then pulse done for 1 cycle, clear busy and return to IDLE.
  - start is ignored outside IDLE.
- Pipeline:
  - s1_adv = s1_v && (!s2_v || out_ready).
  - On s1_adv, the stage-2 register loads core_y with lanes >= R forced to 0, together with out_row = rows_out index and out_last = (index == R-1).
  - s2_v clears on out_valid && out_ready when there is no new load.
  - out_valid = s2_v.
- Latency and throughput:
  - A row accepted at edge k appears on out_data after edge k+1.
  - Throughput is 1 row/clk while out_ready=1.
  - Under backpressure, out_data, out_row and out_last hold stable while out_valid=1 && out_ready=0. No row is lost or duplicated.
- Size stability: core_n changes only on an accepted start, so it is constant while any row of the block is in flight.
- Boundaries:
  - R=32 uses the full 5-bit out_row.
  - R=4 blocks run back-to-back with one IDLE cycle between done and the next start acceptance.
  - Simultaneous s2 drain and s1 load in the same cycle is legal and keeps full throughput.
- Arithmetic: the block does no arithmetic on sample data beyond lane zeroing; the counters are 6 bits wide.

Test Plan:
- Reset mid-block: start with size=11, send 10 rows, pulse rst_n low -> all outputs 0, state IDLE, no done. A following size=00 block completes normally.
- size=00, in_valid/out_ready held 1, row r = all lanes r+1 -> 4 outputs on consecutive cycles with out_row 0..3 and out_last on row 3. core_n=00 throughout. Lanes 4..31 of core_x and out_data are 0. done pulses 1 cycle after the row-3 handshake.
- size=11, out_ready toggling 1/0 each cycle, random rows -> 32 outputs equal to a golden model of the core in order. Data holds stable while stalled. in_ready drops when stage 1 is full and stage 2 is stalled.
- start pulsed during RUN with a different size -> ignored, core_n unchanged, block completes with the original R.
- size=01, in_valid with gaps of 0..3 cycles and out_ready=0 for 5 cycles at row 4 -> exactly 8 outputs, out_row 0..7 with no duplicates, busy high until done.
